mby_tag_mc_ring_stop: RTL

Parametrised multicast tag ring stop: the next generation of the single-channel MC tag interface.
- Accepts tags from NUM_CH local channels into per-channel FIFOs.
- Inserts them into free ring slots using round-robin arbitration.
- Forwards occupied ring slots, and ejects slots addressed to this stop.
- Sits between the GMM tag producers and the MC tag ring; one instance per ring stop.

---
 rtl/mby_tag_mc_ring_stop.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mby_tag_mc_ring_stop.sv
// Multicast tag ring stop: per-channel tag FIFOs, round-robin insertion into free ring slots,
// forwarding of occupied slots and ejection of slots addressed to this stop.
// Optional statistics counters are compiled in when MBY_TAG_RING_STATS_EN is defined.
module mby_tag_mc_ring_stop #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4
`ifdef MBY_TAG_RING_STATS_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          cfg_local_id,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*ID_W-1:0]   in_dest,
  input  logic                     ring_in_valid,
  input  logic [DATA_W-1:0]        ring_in_data,
  input  logic [ID_W-1:0]          ring_in_dest,
  output logic                     ring_out_valid,
  output logic [DATA_W-1:0]        ring_out_data,
  output logic [ID_W-1:0]          ring_out_dest,
  output logic                     eject_valid,
  output logic [DATA_W-1:0]        eject_data
`ifdef MBY_TAG_RING_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_ins_cnt,
  output logic [CNT_W-1:0]         stat_stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              ready_en;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] not_empty;
  logic [DATA_W-1:0] head_data [NUM_CH];
  logic [ID_W-1:0]   head_dest [NUM_CH];

  logic              eject_hit;
  logic              fwd;
  logic              slot_free;
  logic              grant_valid;
  logic [PW-1:0]     grant_idx;
  logic              insert;
  logic [PW-1:0]     rr_ptr;

  // Holds in_ready low during reset and releases it on the first clock edge afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign in_ready = {NUM_CH{ready_en}} & ~full;
  assign push     = in_valid & in_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [ID_W-1:0]   dest_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
      if (push[g]) begin
        data_mem[wr_ptr] <= in_data[g*DATA_W +: DATA_W];
        dest_mem[wr_ptr] <= in_dest[g*ID_W +: ID_W];
      end
    end

    assign full[g]      = (count == CW'(FIFO_DEPTH));
    assign not_empty[g] = (count != '0);
    assign head_data[g] = data_mem[rd_ptr];
    assign head_dest[g] = dest_mem[rd_ptr];
  end

  assign eject_hit = ring_in_valid && (ring_in_dest == cfg_local_id);
  assign fwd       = ring_in_valid && !eject_hit;
  assign slot_free = !fwd;

  // Round-robin scan starting at rr_ptr; iterating downwards lets the closest requester win.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_p       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_p = idx[PW-1:0];
      if (not_empty[idx_p]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_p;
      end
    end
  end

  assign insert = slot_free && grant_valid;

  always_comb begin
    pop = '0;
    if (insert) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_out_valid <= 1'b0;
      ring_out_data  <= '0;
      ring_out_dest  <= '0;
      eject_valid    <= 1'b0;
      eject_data     <= '0;
      rr_ptr         <= '0;
    end else begin
      ring_out_valid <= fwd || insert;
      if (fwd) begin
        ring_out_data <= ring_in_data;
        ring_out_dest <= ring_in_dest;
      end else if (insert) begin
        ring_out_data <= head_data[grant_idx];
        ring_out_dest <= head_dest[grant_idx];
      end else begin
        ring_out_data <= '0;
        ring_out_dest <= '0;
      end
      eject_valid <= eject_hit;
      if (eject_hit) eject_data <= ring_in_data;
      if (insert) begin
        rr_ptr <= (grant_idx == PW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef MBY_TAG_RING_STATS_EN
  // Saturating counters; a stall is a forwarded slot while any local tag is waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ins_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (insert && (stat_ins_cnt != '1)) stat_ins_cnt <= stat_ins_cnt + 1'b1;
      if (fwd && (|not_empty) && (stat_stall_cnt != '1)) stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
